multicycle_ctrl: RTL and testbench

//  Multi-cycle main control FSM for the RV32I subset core (R-type ALU, I-type ALU, LW, SW, LUI).

---
 rtl/multicycle_ctrl_pkg.sv | 59 +++++
 rtl/multicycle_ctrl_decode.sv | 42 ++++
 rtl/multicycle_ctrl.sv | 140 ++++++++++++++
 tb/tb_multicycle_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I-subset control path: opcodes, ImmSel/ALUOp/WBSel
// values, FSM states and the latched instruction class.
package multicycle_ctrl_pkg;

  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned FUNCT3_W = 3;
  localparam int unsigned IMMSEL_W = 2;
  localparam int unsigned ALUOP_W  = 2;

  localparam logic [OPCODE_W-1:0] OP_R   = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_I   = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_LW  = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_SW  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_LUI = 7'b0110111;

  localparam logic [FUNCT3_W-1:0] F3_WORD = 3'b010;

  // Shared with the immediate generator.
  localparam logic [IMMSEL_W-1:0] IMM_I = 2'b00;
  localparam logic [IMMSEL_W-1:0] IMM_S = 2'b01;
  localparam logic [IMMSEL_W-1:0] IMM_U = 2'b10;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_PASSB = 2'b10;

  localparam logic WB_ALU = 1'b0;
  localparam logic WB_MEM = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    CLS_NONE, CLS_R, CLS_I, CLS_LW, CLS_SW, CLS_LUI
  } cls_t;

  typedef struct packed {
    logic [IMMSEL_W-1:0] imm_sel;
    logic                alu_src_b;
    logic [ALUOP_W-1:0]  alu_op;
  } exec_ctrl_t;

  // Datapath steering for the execute step of each instruction class.
  function automatic exec_ctrl_t exec_ctrl(input cls_t cls);
    exec_ctrl_t ec;
    ec = '{imm_sel: IMM_I, alu_src_b: 1'b0, alu_op: ALUOP_ADD};
    case (cls)
      CLS_R:   ec = '{imm_sel: IMM_I, alu_src_b: 1'b0, alu_op: ALUOP_FUNCT};
      CLS_I:   ec = '{imm_sel: IMM_I, alu_src_b: 1'b1, alu_op: ALUOP_FUNCT};
      CLS_LW:  ec = '{imm_sel: IMM_I, alu_src_b: 1'b1, alu_op: ALUOP_ADD};
      CLS_SW:  ec = '{imm_sel: IMM_S, alu_src_b: 1'b1, alu_op: ALUOP_ADD};
      CLS_LUI: ec = '{imm_sel: IMM_U, alu_src_b: 1'b1, alu_op: ALUOP_PASSB};
      default: ec = '{imm_sel: IMM_I, alu_src_b: 1'b0, alu_op: ALUOP_ADD};
    endcase
    return ec;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational opcode/funct3 classifier; loads/stores are legal only as word accesses.
module ctrl_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT3_W-1:0] funct3,
  output cls_t                cls_c,
  output logic                legal_c
);

  always_comb begin
    cls_c   = CLS_NONE;
    legal_c = 1'b0;
    case (opcode)
      OP_R: begin
        cls_c   = CLS_R;
        legal_c = 1'b1;
      end
      OP_I: begin
        cls_c   = CLS_I;
        legal_c = 1'b1;
      end
      OP_LW: begin
        cls_c   = CLS_LW;
        legal_c = (funct3 == F3_WORD);
      end
      OP_SW: begin
        cls_c   = CLS_SW;
        legal_c = (funct3 == F3_WORD);
      end
      OP_LUI: begin
        cls_c   = CLS_LUI;
        legal_c = 1'b1;
      end
      default: begin
        cls_c   = CLS_NONE;
        legal_c = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM: sequences fetch/decode/execute/memory/writeback one instruction at a time,
// stalls on mem_ready, traps permanently on unsupported encodings and counts retirements.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic [1:0]       ImmSel,
  output logic             ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             WBSel,
  output logic             illegal_inst,
  output logic [CNT_W-1:0] retired
);

  state_t     state_q;
  state_t     state_d;
  cls_t       cls_q;
  cls_t       dec_cls_c;
  logic       dec_legal_c;
  logic       retire_c;
  exec_ctrl_t ec_c;

  ctrl_decode u_decode (
    .opcode  (opcode),
    .funct3  (funct3),
    .cls_c   (dec_cls_c),
    .legal_c (dec_legal_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Instruction class is captured once per instruction and steers EXEC/MEM/WB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cls_q <= CLS_NONE;
    end else if (state_q == S_DECODE) begin
      cls_q <= dec_cls_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired <= '0;
    end else if (retire_c) begin
      retired <= retired + CNT_W'(1);
    end
  end

  // Next state and strobes; everything is decoded from the state register so reset
  // silences the strobes without waiting for a clock edge.
  always_comb begin
    state_d      = state_q;
    retire_c     = 1'b0;
    ec_c         = exec_ctrl(cls_q);
    PCWrite      = 1'b0;
    IRWrite      = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    RegWrite     = 1'b0;
    ImmSel       = IMM_I;
    ALUSrcB      = 1'b0;
    ALUOp        = ALUOP_ADD;
    WBSel        = WB_ALU;
    illegal_inst = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end

      S_FETCH: begin
        MemRead = 1'b1;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        state_d = dec_legal_c ? S_EXEC : S_TRAP;
      end

      S_EXEC: begin
        ImmSel  = ec_c.imm_sel;
        ALUSrcB = ec_c.alu_src_b;
        ALUOp   = ec_c.alu_op;
        state_d = (cls_q == CLS_LW || cls_q == CLS_SW) ? S_MEM : S_WB;
      end

      S_MEM: begin
        ImmSel   = ec_c.imm_sel;
        MemRead  = (cls_q == CLS_LW);
        MemWrite = (cls_q == CLS_SW);
        if (mem_ready) begin
          if (cls_q == CLS_SW) begin
            retire_c = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d  = S_WB;
          end
        end
      end

      S_WB: begin
        ImmSel   = ec_c.imm_sel;
        RegWrite = 1'b1;
        WBSel    = (cls_q == CLS_LW) ? WB_MEM : WB_ALU;
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end

      S_TRAP: begin
        illegal_inst = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed vector table, reset/wrap sequences and
// randomized instruction streams checked cycle by cycle against a per-instruction timeline model.
module tb_multicycle_ctrl;

  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             rst;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             mem_ready;
  logic             PCWrite, IRWrite, MemRead, MemWrite, RegWrite;
  logic [1:0]       ImmSel;
  logic             ALUSrcB;
  logic [1:0]       ALUOp;
  logic             WBSel;
  logic             illegal_inst;
  logic [CNT_W-1:0] retired;

  multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .funct3       (funct3),
    .mem_ready    (mem_ready),
    .PCWrite      (PCWrite),
    .IRWrite      (IRWrite),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .RegWrite     (RegWrite),
    .ImmSel       (ImmSel),
    .ALUSrcB      (ALUSrcB),
    .ALUOp        (ALUOp),
    .WBSel        (WBSel),
    .illegal_inst (illegal_inst),
    .retired      (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One expected cycle: the mem_ready to drive and the 12 observed control bits
  // {PCWrite,IRWrite,MemRead,MemWrite,RegWrite,ImmSel,ALUSrcB,ALUOp,WBSel,illegal_inst}.
  typedef struct packed {
    logic        mr;
    logic [11:0] out;
  } exp_t;

  typedef struct {
    logic [31:0] inst;
    int          fw;
    int          mw;
    int          lat;
    logic [1:0]  imm;
  } vec_t;

  int               checks;
  int               errors;
  logic [CNT_W-1:0] ref_ret;
  exp_t             tl[$];
  logic             tl_legal;
  vec_t             vt[8];

  function automatic logic [11:0] dut_out();
    return {PCWrite, IRWrite, MemRead, MemWrite, RegWrite, ImmSel, ALUSrcB, ALUOp, WBSel,
            illegal_inst};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(1, 0));
  endfunction

  function automatic exp_t mk(input logic mr, input logic pcw, input logic irw, input logic mrd,
                              input logic mwr, input logic rw, input logic [1:0] imm,
                              input logic srcb, input logic [1:0] aop, input logic wbs,
                              input logic ill);
    return {mr, pcw, irw, mrd, mwr, rw, imm, srcb, aop, wbs, ill};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference timeline of one instruction, built from the instruction's class and the
  // number of stalled fetch (fw) and memory (mw) cycles.
  task automatic build(input logic [31:0] inst, input int fw, input int mw);
    logic [6:0] op;
    logic [2:0] f3;
    int         k;
    logic [1:0] imm;
    logic [1:0] aop;
    logic       srcb;
    op = inst[6:0];
    f3 = inst[14:12];
    case (op)
      7'b0110011: k = 0;
      7'b0010011: k = 1;
      7'b0000011: k = (f3 == 3'b010) ? 2 : -1;
      7'b0100011: k = (f3 == 3'b010) ? 3 : -1;
      7'b0110111: k = 4;
      default:    k = -1;
    endcase
    tl.delete();
    tl_legal = (k >= 0);
    for (int i = 0; i < fw; i++) tl.push_back(mk(0, 0,0,1,0,0, 2'b00,0,2'b00,0,0));
    tl.push_back(mk(1, 1,1,1,0,0, 2'b00,0,2'b00,0,0));
    tl.push_back(mk(rb(), 0,0,0,0,0, 2'b00,0,2'b00,0,0));
    if (k < 0) begin
      for (int i = 0; i < 20; i++) tl.push_back(mk(rb(), 0,0,0,0,0, 2'b00,0,2'b00,0,1));
      return;
    end
    imm  = (k == 3) ? 2'b01 : (k == 4) ? 2'b10 : 2'b00;
    srcb = (k != 0);
    aop  = (k == 4) ? 2'b10 : (k <= 1) ? 2'b01 : 2'b00;
    tl.push_back(mk(rb(), 0,0,0,0,0, imm,srcb,aop,0,0));
    if (k == 2 || k == 3) begin
      for (int i = 0; i < mw; i++)
        tl.push_back(mk(0, 0,0,(k == 2),(k == 3),0, imm,0,2'b00,0,0));
      tl.push_back(mk(1, 0,0,(k == 2),(k == 3),0, imm,0,2'b00,0,0));
    end
    if (k != 3) tl.push_back(mk(rb(), 0,0,0,0,1, imm,0,2'b00,(k == 2),0));
  endtask

  // Called at posedge+1 while in FETCH; drives and checks every cycle of one instruction.
  task automatic run_inst(input logic [31:0] inst, input int fw, input int mw, output int lat,
                          output logic [1:0] eimm);
    logic [CNT_W-1:0] prev;
    build(inst, fw, mw);
    opcode = inst[6:0];
    funct3 = inst[14:12];
    lat    = 0;
    eimm   = 2'bxx;
    prev   = retired;
    for (int i = 0; i < tl.size(); i++) begin
      mem_ready = tl[i].mr;
      @(negedge clk);
      check($sformatf("%08h cyc%0d ctrl", inst, i), 32'(dut_out()), 32'(tl[i].out));
      if (i == fw + 2) eimm = ImmSel;
      @(posedge clk); #1;
      if (lat == 0 && retired !== prev) lat = i + 1;
    end
    if (tl_legal) ref_ret = ref_ret + CNT_W'(1);
    check($sformatf("%08h retired", inst), 32'(retired), 32'(ref_ret));
  endtask

  // Called at posedge+1; asserts reset mid-cycle and leaves the DUT at the start of FETCH.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check("reset ctrl", 32'(dut_out()), 32'h0);
    check("reset retired", 32'(retired), 32'h0);
    ref_ret = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle ctrl", 32'(dut_out()), 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    int          lat;
    logic [1:0]  eimm;
    logic [31:0] inst;
    int          k;
    checks    = 0;
    errors    = 0;
    ref_ret   = '0;
    rst       = 1'b0;
    opcode    = '0;
    funct3    = '0;
    mem_ready = 1'b0;

    vt[0] = '{32'h00B50533, 0, 0, 4, 2'b00};
    vt[1] = '{32'h00452283, 0, 3, 8, 2'b00};
    vt[2] = '{32'h0062A223, 0, 0, 4, 2'b01};
    vt[3] = '{32'h0062A223, 1, 2, 7, 2'b01};
    vt[4] = '{32'h123452B7, 0, 0, 4, 2'b10};
    vt[5] = '{32'h00A00093, 2, 0, 6, 2'b00};
    vt[6] = '{32'h00000063, 0, 0, 0, 2'b00};
    vt[7] = '{32'h00050283, 1, 0, 0, 2'b00};

    #1;
    do_reset();

    for (int i = 0; i < 8; i++) begin
      run_inst(vt[i].inst, vt[i].fw, vt[i].mw, lat, eimm);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(vt[i].lat));
      check($sformatf("vec%0d exec ImmSel", i), 32'(eimm), 32'(vt[i].imm));
      if (illegal_inst) do_reset();
    end

    // Reset in the middle of a stalled store drops MemWrite without a clock edge.
    run_inst(32'h00B50533, 0, 0, lat, eimm);
    opcode    = 7'b0100011;
    funct3    = 3'b010;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("sw stall MemWrite", 32'(MemWrite), 32'h1);
    @(posedge clk); #1;
    check("sw stall retired", 32'(retired), 32'(ref_ret));
    do_reset();

    // Counter wraps after 2^CNT_W retirements.
    for (int i = 0; i < 15; i++) run_inst(32'h00B50533, 0, 0, lat, eimm);
    check("retired at max", 32'(retired), 32'hF);
    run_inst(32'h0062A223, 0, 1, lat, eimm);
    check("retired wrapped", 32'(retired), 32'h0);

    for (int n = 0; n < 80; n++) begin
      inst = $urandom;
      k    = $urandom_range(0, 5);
      case (k)
        0: inst[6:0] = 7'b0110011;
        1: inst[6:0] = 7'b0010011;
        2: begin inst[6:0] = 7'b0000011; inst[14:12] = 3'b010; end
        3: begin inst[6:0] = 7'b0100011; inst[14:12] = 3'b010; end
        4: inst[6:0] = 7'b0110111;
        default: begin
          if (rb()) begin
            inst[6:0] = 7'b1100011;
          end else begin
            inst[6:0]   = rb() ? 7'b0000011 : 7'b0100011;
            inst[14:12] = 3'($urandom_range(7, 3));
          end
        end
      endcase
      run_inst(inst, $urandom_range(0, 3), $urandom_range(0, 3), lat, eimm);
      if (!tl_legal) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
